// File: rtl/watch_time_setter.sv
// ============================================================================
// Module      : watch_time_setter
// Description : Button-driven time-setting controller. Snapshots the live
//               time into a shadow copy, steps through and adjusts each
//               field, then commits the shadow with a one-cycle set_time
//               strobe. Optional feature macro: EDIT_TIMEOUT_EN (abort an
//               edit after TIMEOUT_SEC seconds without an accepted button).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_time_setter #(
  parameter int TIMEOUT_SEC = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic [51:0] cur_time,
  output logic        set_time,
  output logic [51:0] bin_time,
  output logic        edit_active,
  output logic [2:0]  edit_field,
  output logic        blink
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] year_q, year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q, day_d;
  logic [7:0]  hour_q, hour_d;
  logic [7:0]  minute_q, minute_d;
  logic [7:0]  second_q, second_d;
  logic        set_time_q, set_time_d;
  logic        edit_active_q, edit_active_d;
  logic [2:0]  edit_field_q, edit_field_d;
  logic        blink_q, blink_d;
  logic        btn_accept;
  logic        step_up;
  logic [7:0]  maxd;
  logic [7:0]  new_month;
  logic [11:0] new_year;

  // Number of days in month m of year y (Gregorian leap rule).
  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [11:0] y);
    logic leap;
    leap = ((y % 12'd4 == 12'd0) && (y % 12'd100 != 12'd0)) || (y % 12'd400 == 12'd0);
    case (m)
      8'd2:                       days_in_month = leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:    days_in_month = 8'd30;
      default:                    days_in_month = 8'd31;
    endcase
  endfunction

  // One wrapping step within lo..hi; out-of-range values snap to the wrap target.
  function automatic logic [7:0] step8(input logic [7:0] v, input logic [7:0] lo,
                                       input logic [7:0] hi, input logic up);
    if (up) step8 = (v >= hi) ? lo : v + 8'd1;
    else    step8 = (v <= lo) ? hi : v - 8'd1;
  endfunction

  // Day limit always follows the shadow copy, never the running clock.
  assign maxd    = days_in_month(month_q, year_q);
  assign step_up = btn_inc;

`ifdef EDIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // Next-state, shadow edit and output computation.
  always_comb begin
    state_d       = state_q;
    year_d        = year_q;
    month_d       = month_q;
    day_d         = day_q;
    hour_d        = hour_q;
    minute_d      = minute_q;
    second_d      = second_q;
    set_time_d    = 1'b0;
    edit_active_d = edit_active_q;
    edit_field_d  = edit_field_q;
    blink_d       = blink_q;
    btn_accept    = 1'b0;
    new_month     = month_q;
    new_year      = year_q;

    case (state_q)
      ST_IDLE: begin
        edit_active_d = 1'b0;
        edit_field_d  = 3'd0;
        blink_d       = 1'b0;
        if (btn_mode) begin
          {year_d, month_d, day_d, hour_d, minute_d, second_d} = cur_time;
          state_d       = ST_EDIT;
          edit_active_d = 1'b1;
          blink_d       = 1'b1;
        end
      end

      ST_EDIT: begin
        if (btn_cancel) begin
          state_d       = ST_IDLE;
          edit_active_d = 1'b0;
          edit_field_d  = 3'd0;
          blink_d       = 1'b0;
        end else if (btn_mode) begin
          btn_accept = 1'b1;
          blink_d    = 1'b1;
          if (edit_field_q >= 3'd5) begin
            state_d    = ST_COMMIT;
            set_time_d = 1'b1;
          end else begin
            edit_field_d = edit_field_q + 3'd1;
          end
        end else if (btn_inc ^ btn_dec) begin
          btn_accept = 1'b1;
          blink_d    = 1'b1;
          case (edit_field_q)
            3'd0: begin
              if (step_up) new_year = (year_q >= 12'd4095) ? 12'd1 : year_q + 12'd1;
              else         new_year = (year_q <= 12'd1) ? 12'd4095 : year_q - 12'd1;
              year_d = new_year;
              day_d  = (day_q > days_in_month(month_q, new_year)) ?
                       days_in_month(month_q, new_year) : day_q;
            end
            3'd1: begin
              new_month = step8(month_q, 8'd1, 8'd12, step_up);
              month_d   = new_month;
              day_d     = (day_q > days_in_month(new_month, year_q)) ?
                          days_in_month(new_month, year_q) : day_q;
            end
            3'd2:    day_d    = step8(day_q, 8'd1, maxd, step_up);
            3'd3:    hour_d   = step8(hour_q, 8'd0, 8'd23, step_up);
            3'd4:    minute_d = step8(minute_q, 8'd0, 8'd59, step_up);
            3'd5:    second_d = step8(second_q, 8'd0, 8'd59, step_up);
            default: ;
          endcase
        end else if (clk1sec) begin
          blink_d = ~blink_q;
        end
      end

      ST_COMMIT: begin
        state_d       = ST_IDLE;
        edit_active_d = 1'b0;
        edit_field_d  = 3'd0;
        blink_d       = 1'b0;
      end

      default: begin
        state_d       = ST_IDLE;
        edit_active_d = 1'b0;
        edit_field_d  = 3'd0;
        blink_d       = 1'b0;
      end
    endcase

`ifdef EDIT_TIMEOUT_EN
    // Inactivity abort behaves exactly like a cancel.
    idle_cnt_d = '0;
    if (state_q == ST_EDIT && !btn_cancel && !btn_accept && clk1sec) begin
      if (idle_cnt_q >= CNT_W'(TIMEOUT_SEC - 1)) begin
        state_d       = ST_IDLE;
        edit_active_d = 1'b0;
        edit_field_d  = 3'd0;
        blink_d       = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end else if (state_q == ST_EDIT && !btn_cancel && !btn_accept) begin
      idle_cnt_d = idle_cnt_q;
    end
`endif
  end

  // State and shadow registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      year_q        <= '0;
      month_q       <= '0;
      day_q         <= '0;
      hour_q        <= '0;
      minute_q      <= '0;
      second_q      <= '0;
      set_time_q    <= 1'b0;
      edit_active_q <= 1'b0;
      edit_field_q  <= 3'd0;
      blink_q       <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      idle_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      year_q        <= year_d;
      month_q       <= month_d;
      day_q         <= day_d;
      hour_q        <= hour_d;
      minute_q      <= minute_d;
      second_q      <= second_d;
      set_time_q    <= set_time_d;
      edit_active_q <= edit_active_d;
      edit_field_q  <= edit_field_d;
      blink_q       <= blink_d;
`ifdef EDIT_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
`endif
    end
  end

  assign set_time    = set_time_q;
  assign bin_time    = {year_q, month_q, day_q, hour_q, minute_q, second_q};
  assign edit_active = edit_active_q;
  assign edit_field  = edit_field_q;
  assign blink       = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_watch_time_setter.sv
// ============================================================================
// Module      : tb_watch_time_setter
// Description : Directed self-checking bench for watch_time_setter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_time_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk1sec = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic        btn_cancel = 1'b0;
  logic [51:0] cur_time = '0;
  logic        set_time;
  logic [51:0] bin_time;
  logic        edit_active;
  logic [2:0]  edit_field;
  logic        blink;

  int n_checks = 0;
  int n_errors = 0;
  int st_cnt   = 0;

  watch_time_setter #(.TIMEOUT_SEC(3)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .clk1sec     (clk1sec),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .btn_cancel  (btn_cancel),
    .cur_time    (cur_time),
    .set_time    (set_time),
    .bin_time    (bin_time),
    .edit_active (edit_active),
    .edit_field  (edit_field),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  // Count commit strobes seen over the whole run.
  always @(negedge clk) if (set_time === 1'b1) st_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [51:0] pk(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    pk = {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d, input logic c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    tick();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
  endtask

  task automatic sec();
    clk1sec = 1'b1;
    tick();
    clk1sec = 1'b0;
  endtask

  // Enter edit from IDLE and advance to field f.
  task automatic enter_to(input int f);
    press(1, 0, 0, 0);
    repeat (f) press(1, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_set_time", set_time, 0);
    check("rst_bin_time", bin_time, 0);
    check("rst_active", edit_active, 0);
    check("rst_field", edit_field, 0);
    check("rst_blink", blink, 0);

    // Test 1: capture and commit unchanged
    cur_time = pk(2021, 6, 9, 10, 20, 30);
    press(1, 0, 0, 0);
    check("t1_active", edit_active, 1);
    check("t1_field0", edit_field, 0);
    check("t1_blink", blink, 1);
    check("t1_capture", bin_time, pk(2021, 6, 9, 10, 20, 30));
    cur_time = pk(2021, 6, 9, 10, 20, 45);
    repeat (5) press(1, 0, 0, 0);
    check("t1_field5", edit_field, 5);
    check("t1_no_early_commit", set_time, 0);
    press(1, 0, 0, 0);
    check("t1_set_time", set_time, 1);
    check("t1_commit_val", bin_time, pk(2021, 6, 9, 10, 20, 30));
    tick();
    check("t1_set_time_off", set_time, 0);
    check("t1_idle_active", edit_active, 0);
    check("t1_idle_field", edit_field, 0);
    check("t1_idle_blink", blink, 0);
    check("t1_hold", bin_time, pk(2021, 6, 9, 10, 20, 30));

    // Buttons other than mode are ignored in IDLE
    press(0, 1, 0, 0); press(0, 0, 1, 0); press(0, 0, 0, 1); sec();
    check("idle_ignore_val", bin_time, pk(2021, 6, 9, 10, 20, 30));
    check("idle_ignore_act", edit_active, 0);
    check("idle_blink", blink, 0);

    // Test 2: hour/minute wrap, blink, inc+dec no-op, cancel
    cur_time = pk(2000, 1, 15, 23, 0, 0);
    enter_to(3);
    press(0, 1, 0, 0);
    check("hour_wrap_up", bin_time, pk(2000, 1, 15, 0, 0, 0));
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    check("min_wrap_dn", bin_time, pk(2000, 1, 15, 0, 59, 0));
    sec();
    check("blink_toggle0", blink, 0);
    press(0, 1, 1, 0);
    check("incdec_noop", bin_time, pk(2000, 1, 15, 0, 59, 0));
    check("incdec_blink", blink, 0);
    sec();
    check("blink_toggle1", blink, 1);
    press(0, 0, 0, 1);
    check("cancel_active", edit_active, 0);
    check("cancel_field", edit_field, 0);
    check("cancel_set", set_time, 0);

    // Year wrap both directions
    cur_time = pk(4095, 3, 10, 1, 2, 3);
    enter_to(0);
    press(0, 1, 0, 0);
    check("year_wrap_up", bin_time, pk(1, 3, 10, 1, 2, 3));
    press(0, 0, 1, 0);
    check("year_wrap_dn", bin_time, pk(4095, 3, 10, 1, 2, 3));
    press(0, 0, 1, 0);
    check("year_dec", bin_time, pk(4094, 3, 10, 1, 2, 3));
    press(0, 0, 0, 1);

    // Test 3: day clamp on month and year change
    cur_time = pk(2024, 1, 31, 12, 0, 0);
    enter_to(1);
    press(0, 1, 0, 0);
    check("clamp_month", bin_time, pk(2024, 2, 29, 12, 0, 0));
    repeat (4) press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    check("t3_commit", set_time, 1);
    check("t3_commit_val", bin_time, pk(2024, 2, 29, 12, 0, 0));
    tick();
    cur_time = pk(2024, 2, 29, 12, 0, 0);
    enter_to(0);
    press(0, 1, 0, 0);
    check("clamp_year", bin_time, pk(2025, 2, 28, 12, 0, 0));
    press(0, 0, 1, 0);
    check("no_regrow", bin_time, pk(2024, 2, 28, 12, 0, 0));
    press(0, 0, 0, 1);

    // Test 4: February day wrap across leap rules
    cur_time = pk(2023, 2, 28, 0, 0, 0);
    enter_to(2);
    press(0, 1, 0, 0);
    check("feb2023_wrap", bin_time, pk(2023, 2, 1, 0, 0, 0));
    press(0, 0, 0, 1);
    cur_time = pk(2024, 2, 28, 0, 0, 0);
    enter_to(2);
    press(0, 1, 0, 0);
    check("feb2024_29", bin_time, pk(2024, 2, 29, 0, 0, 0));
    press(0, 1, 0, 0);
    check("feb2024_wrap", bin_time, pk(2024, 2, 1, 0, 0, 0));
    press(0, 0, 1, 0);
    check("feb2024_dn", bin_time, pk(2024, 2, 29, 0, 0, 0));
    press(0, 0, 0, 1);
    cur_time = pk(2100, 2, 28, 0, 0, 0);
    enter_to(2);
    press(0, 1, 0, 0);
    check("feb2100_wrap", bin_time, pk(2100, 2, 1, 0, 0, 0));
    press(0, 0, 0, 1);
    cur_time = pk(2000, 2, 28, 0, 0, 0);
    enter_to(2);
    press(0, 1, 0, 0);
    check("feb2000_29", bin_time, pk(2000, 2, 29, 0, 0, 0));
    press(0, 0, 0, 1);
    cur_time = pk(2023, 1, 5, 0, 0, 0);
    enter_to(1);
    press(0, 0, 1, 0);
    check("month_wrap_dn", bin_time, pk(2023, 12, 5, 0, 0, 0));
    press(0, 0, 0, 1);

    // Test 5: reset mid-edit
    cur_time = pk(2022, 7, 7, 7, 7, 7);
    enter_to(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_active", edit_active, 0);
    check("rst_mid_field", edit_field, 0);
    check("rst_mid_set", set_time, 0);
    check("rst_mid_bin", bin_time, 0);

    // Test 6: inactivity behaviour
    cur_time = pk(2030, 5, 5, 5, 5, 5);
    enter_to(0);
`ifdef EDIT_TIMEOUT_EN
    sec(); sec();
    check("to_still_edit", edit_active, 1);
    sec();
    check("to_abort", edit_active, 0);
    check("to_field", edit_field, 0);
    check("to_no_set", set_time, 0);
`else
    repeat (100) sec();
    check("no_to_edit", edit_active, 1);
    check("no_to_field", edit_field, 0);
    press(0, 0, 0, 1);
    check("no_to_cancel", edit_active, 0);
`endif

    tick();
    check("commit_count", st_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
